// File: rtl/wlan_scrambler_par.sv
// DW-bit-per-beat 802.11a scrambler/descrambler (x^7+x^4+1) with framing, handshakes and seed recovery.
// Define SCR_BYPASS_EN to add a per-frame bypass input that passes data through unscrambled.
module wlan_scrambler_par #(
  parameter int         DW           = 4,
  parameter int         LEN_W        = 16,
  parameter logic [6:0] SEED_DEFAULT = 7'h7F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [6:0]       seed_in,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic             busy,
  output logic [6:0]       seed_out,
  output logic             seed_valid
`ifdef SCR_BYPASS_EN
  ,
  input  logic             bypass
`endif
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             start_ok_s;
  logic             mode_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [2:0]       rec_r;
  logic [6:0]       s_r;
  logic             out_valid_r;
  logic [DW-1:0]    out_data_r;
  logic             out_last_r;
  logic [6:0]       seed_out_r;
  logic             seed_valid_r;
  logic             bypass_r;
  logic             bypass_start_s;

  logic             busy_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             last_beat_s;

  logic [6:0]       s_v;
  logic [2:0]       rec_v;
  logic             fb_v;
  logic [DW-1:0]    dout_s;
  logic [6:0]       s_nxt_s;
  logic [6:0]       seed_cap_s;
  logic             seed_hit_s;

  assign busy_s      = (state_r == RUN) || out_valid_r;
  assign in_ready_s  = (state_r == RUN) && (!out_valid_r || out_ready);
  assign accept_s    = in_valid && in_ready_s;
  assign last_beat_s = (cnt_r == (len_r - LEN_ONE));

`ifdef SCR_BYPASS_EN
  assign bypass_start_s = bypass;

  // Bypass flag captured for the duration of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      bypass_r <= 1'b0;
    end else if (start_ok_s) begin
      bypass_r <= bypass;
    end else begin
      bypass_r <= bypass_r;
    end
  end
`else
  assign bypass_start_s = 1'b0;
  assign bypass_r       = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: starts are honoured only when fully idle with a non-empty frame.
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !busy_s && (frame_len != {LEN_W{1'b0}})) begin
          start_ok_s  = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_beat_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Unrolled per-bit recursion; recovery bits shift the received bit in and emit 0.
  always_comb begin
    s_v        = s_r;
    rec_v      = rec_r;
    fb_v       = 1'b0;
    dout_s     = {DW{1'b0}};
    seed_cap_s = s_r;
    for (int i = 0; i < DW; i++) begin
      if (bypass_r) begin
        dout_s[i] = in_data[i];
      end else if (mode_r && (rec_v != 3'd7)) begin
        dout_s[i]  = 1'b0;
        s_v        = {s_v[5:0], in_data[i]};
        rec_v      = rec_v + 3'd1;
        seed_cap_s = s_v;
      end else begin
        fb_v      = s_v[6] ^ s_v[3];
        dout_s[i] = in_data[i] ^ fb_v;
        s_v       = {s_v[5:0], fb_v};
      end
    end
    s_nxt_s    = bypass_r ? s_r : s_v;
    seed_hit_s = mode_r && !bypass_r && (rec_r != 3'd7) && (rec_v == 3'd7);
  end

  // Frame context, scrambler state, seed reporting and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r       <= 1'b0;
      len_r        <= {LEN_W{1'b0}};
      cnt_r        <= {LEN_W{1'b0}};
      rec_r        <= 3'd0;
      s_r          <= SEED_DEFAULT;
      seed_out_r   <= SEED_DEFAULT;
      seed_valid_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {DW{1'b0}};
      out_last_r   <= 1'b0;
    end else begin
      seed_valid_r <= 1'b0;
      if (start_ok_s) begin
        mode_r <= mode;
        len_r  <= frame_len;
        cnt_r  <= {LEN_W{1'b0}};
        rec_r  <= 3'd0;
        if (bypass_start_s) begin
          s_r <= s_r;
        end else if (mode) begin
          s_r <= 7'h00;
        end else begin
          s_r          <= seed_in;
          seed_out_r   <= seed_in;
          seed_valid_r <= 1'b1;
        end
      end else if (accept_s) begin
        s_r   <= s_nxt_s;
        cnt_r <= cnt_r + LEN_ONE;
        rec_r <= rec_v;
        if (seed_hit_s) begin
          seed_out_r   <= seed_cap_s;
          seed_valid_r <= 1'b1;
        end else begin
          seed_out_r <= seed_out_r;
        end
      end else begin
        s_r <= s_r;
      end

      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= dout_s;
        out_last_r  <= last_beat_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_last   = out_last_r;
  assign busy       = busy_s;
  assign seed_out   = seed_out_r;
  assign seed_valid = seed_valid_r;

endmodule

// File: tb/tb_wlan_scrambler_par.sv
// Directed self-checking bench for wlan_scrambler_par: DW=4 instance plus a DW=1 instance.
module tb_wlan_scrambler_par;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, mode, in_valid, out_ready;
  logic [6:0]  seed_in;
  logic [15:0] frame_len;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, out_last, busy, seed_valid;
  logic [3:0]  out_data;
  logic [6:0]  seed_out;

  logic        start1, mode1, in_valid1, out_ready1;
  logic [6:0]  seed_in1;
  logic [15:0] frame_len1;
  logic [0:0]  in_data1;
  logic        in_ready1, out_valid1, out_last1, busy1, seed_valid1;
  logic [0:0]  out_data1;
  logic [6:0]  seed_out1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ref_seq [4] = '{4'h0, 4'h7, 4'hF, 4'h4};

  always #5 clk = ~clk;

  wlan_scrambler_par #(.DW(4), .LEN_W(16), .SEED_DEFAULT(7'h7F)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed_in(seed_in),
    .frame_len(frame_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .seed_out(seed_out), .seed_valid(seed_valid)
  );

  wlan_scrambler_par #(.DW(1), .LEN_W(16), .SEED_DEFAULT(7'h7F)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode1), .seed_in(seed_in1),
    .frame_len(frame_len1), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1),
    .busy(busy1), .seed_out(seed_out1), .seed_valid(seed_valid1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; seed_in = 7'h00; frame_len = 16'd0;
    in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
    start1 = 1'b0; mode1 = 1'b0; seed_in1 = 7'h00; frame_len1 = 16'd0;
    in_valid1 = 1'b0; in_data1 = 1'b0; out_ready1 = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hA;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b, expected 0", out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++; if (seed_out !== 7'h7F) begin n_fail++; $display("FAIL reset_seed_out: got %h, expected 7f", seed_out); end
    n_checks++; if (seed_valid !== 1'b0) begin n_fail++; $display("FAIL reset_seed_valid: got %b, expected 0", seed_valid); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_in_valid_ignored: out_valid got %b, expected 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_scramble_ref();
    start = 1'b1; mode = 1'b0; seed_in = 7'h7F; frame_len = 16'd4;
    cyc();
    start = 1'b0;
    n_checks++; if (seed_valid !== 1'b1) begin n_fail++; $display("FAIL ref_seed_pulse: got %b, expected 1", seed_valid); end
    n_checks++; if (seed_out !== 7'h7F) begin n_fail++; $display("FAIL ref_seed_out: got %h, expected 7f", seed_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ref_busy: got %b, expected 1", busy); end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 4'h0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ref_in_ready beat %0d: got %b, expected 1", k, in_ready); end
      cyc();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ref_out_valid beat %0d: got %b, expected 1", k, out_valid); end
      n_checks++; if (out_data !== ref_seq[k]) begin n_fail++; $display("FAIL ref_out_data beat %0d: got %h, expected %h", k, out_data, ref_seq[k]); end
      n_checks++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL ref_out_last beat %0d: got %b, expected %b", k, out_last, (k == 3)); end
      n_checks++; if (seed_valid !== 1'b0) begin n_fail++; $display("FAIL ref_seed_single beat %0d: got %b, expected 0", k, seed_valid); end
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ref_idle_in_ready: got %b, expected 0", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ref_busy_pending: got %b, expected 1", busy); end
    cyc();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ref_drain_valid: got %b, expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ref_drain_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_round_trip();
    logic [31:0] orig;
    logic [31:0] exp_scr;
    logic [31:0] scr;
    logic [31:0] desc;
    logic [6:0]  st;
    logic [6:0]  st7;
    logic [6:0]  got_seed;
    logic        fb;
    int          pulses;
    orig = 32'hA5C3_9E80;
    st   = 7'h5D;
    st7  = 7'h00;
    for (int b = 0; b < 32; b++) begin
      fb         = st[6] ^ st[3];
      exp_scr[b] = orig[b] ^ fb;
      st         = {st[5:0], fb};
      if (b == 6) st7 = st;
    end
    start = 1'b1; mode = 1'b0; seed_in = 7'h5D; frame_len = 16'd8;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = orig[4*k +: 4];
      cyc();
      scr[4*k +: 4] = out_data;
    end
    in_valid = 1'b0;
    cyc();
    n_checks++; if (scr !== exp_scr) begin n_fail++; $display("FAIL rt_scramble: got %h, expected %h", scr, exp_scr); end

    start = 1'b1; mode = 1'b1; frame_len = 16'd8;
    cyc();
    start = 1'b0;
    n_checks++; if (seed_valid !== 1'b0) begin n_fail++; $display("FAIL rt_no_pulse_at_start: got %b, expected 0", seed_valid); end
    pulses   = 0;
    got_seed = 7'h00;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = scr[4*k +: 4];
      cyc();
      desc[4*k +: 4] = out_data;
      if (seed_valid) begin pulses++; got_seed = seed_out; end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      if (seed_valid) begin pulses++; got_seed = seed_out; end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL rt_seed_pulses: got %0d, expected 1", pulses); end
    n_checks++; if (got_seed !== st7) begin n_fail++; $display("FAIL rt_seed_value: got %h, expected %h", got_seed, st7); end
    n_checks++; if (desc[6:0] !== 7'h00) begin n_fail++; $display("FAIL rt_first7_zero: got %h, expected 00", desc[6:0]); end
    n_checks++; if (desc !== orig) begin n_fail++; $display("FAIL rt_descramble: got %h, expected %h", desc, orig); end
  endtask

  task automatic test_backpressure();
    int         sent;
    int         recv;
    logic       prev_stall;
    logic [3:0] prev_data;
    logic       lat_pending;
    int         lat_idx;
    start = 1'b1; mode = 1'b0; seed_in = 7'h7F; frame_len = 16'd4;
    cyc();
    start = 1'b0;
    sent = 0; recv = 0; prev_stall = 1'b0; prev_data = 4'h0; lat_pending = 1'b0; lat_idx = 0;
    for (int c = 0; c < 20 && recv < 4; c++) begin
      out_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      in_valid  = (sent < 4);
      in_data   = 4'h0;
      #1;
      if (prev_stall) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_fail++; $display("FAIL bp_stable cycle %0d: got %b/%h, expected 1/%h", c, out_valid, out_data, prev_data); end
      end
      if (lat_pending) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== ref_seq[lat_idx]) begin n_fail++; $display("FAIL bp_latency cycle %0d: got %b/%h, expected 1/%h", c, out_valid, out_data, ref_seq[lat_idx]); end
      end
      if (out_valid && !out_ready) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall cycle %0d: got %b, expected 0", c, in_ready); end
      end
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      lat_pending = in_valid && in_ready;
      lat_idx     = sent;
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== ref_seq[recv] || out_last !== (recv == 3)) begin n_fail++; $display("FAIL bp_order beat %0d: got %h last %b, expected %h last %b", recv, out_data, out_last, ref_seq[recv], (recv == 3)); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (recv != 4 || sent != 4) begin n_fail++; $display("FAIL bp_count: got recv %0d sent %0d, expected 4 4", recv, sent); end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_idle: got valid %b busy %b, expected 0 0", out_valid, busy); end
  endtask

  task automatic test_ignored_starts();
    start = 1'b1; mode = 1'b0; seed_in = 7'h12; frame_len = 16'd0;
    cyc();
    start = 1'b0;
    n_checks++; if (busy !== 1'b0 || seed_valid !== 1'b0 || seed_out !== 7'h7F) begin n_fail++; $display("FAIL ign_zero_len: got busy %b pulse %b seed %h, expected 0 0 7f", busy, seed_valid, seed_out); end

    start = 1'b1; mode = 1'b0; seed_in = 7'h7F; frame_len = 16'd2;
    cyc();
    start = 1'b1; mode = 1'b1; seed_in = 7'h12; frame_len = 16'd4;
    in_valid = 1'b1; in_data = 4'h0;
    cyc();
    start = 1'b0;
    n_checks++; if (seed_valid !== 1'b0 || seed_out !== 7'h7F) begin n_fail++; $display("FAIL ign_start_run: got pulse %b seed %h, expected 0 7f", seed_valid, seed_out); end
    n_checks++; if (out_data !== 4'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL ign_run_beat0: got %h last %b, expected 0 last 0", out_data, out_last); end
    cyc();
    n_checks++; if (out_data !== 4'h7 || out_last !== 1'b1) begin n_fail++; $display("FAIL ign_run_beat1: got %h last %b, expected 7 last 1", out_data, out_last); end

    in_valid = 1'b0; out_ready = 1'b0;
    start = 1'b1; mode = 1'b0; seed_in = 7'h12; frame_len = 16'd4;
    cyc();
    start = 1'b0;
    n_checks++; if (seed_valid !== 1'b0 || seed_out !== 7'h7F || busy !== 1'b1) begin n_fail++; $display("FAIL ign_start_pending: got pulse %b seed %h busy %b, expected 0 7f 1", seed_valid, seed_out, busy); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h7) begin n_fail++; $display("FAIL ign_hold: got %b/%h, expected 1/7", out_valid, out_data); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ign_still_idle: got busy %b in_ready %b, expected 0 0", busy, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1; mode = 1'b0; seed_in = 7'h2A; frame_len = 16'd4;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; in_data = 4'h0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got busy %b valid %b, expected 0 0", busy, out_valid); end
    n_checks++; if (seed_out !== 7'h7F || seed_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_seed: got %h pulse %b, expected 7f 0", seed_out, seed_valid); end
    n_checks++; if (dut.s_r !== 7'h7F) begin n_fail++; $display("FAIL rst_mid_state: got %h, expected 7f", dut.s_r); end
    start = 1'b1; mode = 1'b0; seed_in = 7'h7F; frame_len = 16'd4;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 4'h0;
      cyc();
      n_checks++; if (out_data !== ref_seq[k] || out_last !== (k == 3)) begin n_fail++; $display("FAIL rst_mid_refseq beat %0d: got %h last %b, expected %h last %b", k, out_data, out_last, ref_seq[k], (k == 3)); end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_dw1_short_descramble();
    logic [2:0] bits;
    bits = 3'b101;
    start1 = 1'b1; mode1 = 1'b1; seed_in1 = 7'h33; frame_len1 = 16'd3;
    cyc();
    start1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid1 = 1'b1;
      in_data1  = bits[k];
      cyc();
      n_checks++; if (out_valid1 !== 1'b1 || out_data1 !== 1'b0 || out_last1 !== (k == 2)) begin n_fail++; $display("FAIL dw1_beat %0d: got valid %b data %b last %b, expected 1 0 %b", k, out_valid1, out_data1, out_last1, (k == 2)); end
      n_checks++; if (seed_valid1 !== 1'b0) begin n_fail++; $display("FAIL dw1_no_pulse beat %0d: got %b, expected 0", k, seed_valid1); end
    end
    in_valid1 = 1'b0;
    cyc();
    n_checks++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin n_fail++; $display("FAIL dw1_idle: got busy %b valid %b ready %b, expected 0 0 0", busy1, out_valid1, in_ready1); end
    n_checks++; if (seed_out1 !== 7'h7F || seed_valid1 !== 1'b0) begin n_fail++; $display("FAIL dw1_seed_hold: got %h pulse %b, expected 7f 0", seed_out1, seed_valid1); end
  endtask

  initial begin
    test_reset();
    test_scramble_ref();
    test_round_trip();
    test_backpressure();
    test_ignored_starts();
    test_reset_mid_frame();
    test_dw1_short_descramble();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wlan_scrambler_par.md
Name: wlan_scrambler_par

Overview:
- Parametrised successor to the bit-serial 802.11a scrambler. Processes DW bits per beat with the x^7+x^4+1 generator.
- Sits between the PLCP/MAC bit source and the convolutional encoder on TX, or between the Viterbi decoder and the MAC on RX.
- Adds frame sequencing, valid/ready handshakes, a programmable seed, and a descramble mode that recovers the seed from the SERVICE field.

Parameters:
- DW, 4, bits per beat (1..8); in_data[0] is the first bit in time.
- LEN_W, 16, width of the frame-length field, counted in beats.
- SEED_DEFAULT, 7'h7F, state loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- mode  in  1  sampled at start; 0 = scramble with seed_in, 1 = descramble with seed recovery.
- seed_in  in  7  initial state, sampled at start when mode=0.
- frame_len  in  LEN_W  beats in the frame, sampled at start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both 1.
- in_data  in  DW  input bits.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream can take the output beat.
- out_data  out  DW  scrambled or descrambled bits.
- out_last  out  1  marks the final beat of the frame.
- busy  out  1  frame in progress or output still pending.
- seed_out  out  7  active seed (scramble mode) or recovered seed (descramble mode).
- seed_valid  out  1  one-cycle pulse when seed_out is updated.

Behaviour:
- State s[6:0]. Per bit, in order i=0..DW-1: fb=s[6]^s[3]; out=in^fb; s={s[5:0],fb}. The DW steps are unrolled combinationally within one cycle.
- Reset values:
  - FSM=IDLE, s=SEED_DEFAULT, beat counter=0, recovery counter=0.
  - in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, seed_out=SEED_DEFAULT, seed_valid=0.
- FSM states are IDLE and RUN.
- IDLE:
  - start=1 with frame_len!=0: latch mode and frame_len, clear the beat counter, go to RUN.
  - In scramble mode the same edge loads s=seed_in, sets seed_out=seed_in and pulses seed_valid.
  - In descramble mode the same edge loads s=7'h00 and clears the recovery counter.
  - start with frame_len=0 is ignored.
  - start while busy=1 is ignored, including in RUN.
- RUN:
  - in_ready = (!out_valid || out_ready).
  - Each accepted beat advances s, increments the beat counter and loads the output register.
  - When the beat with count frame_len-1 is accepted, the FSM returns to IDLE and that output beat has out_last=1.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Full throughput, one beat per cycle, when out_ready is held high.
- Descramble seed recovery: while the recovery counter is below 7, each bit is processed as follows.
  - The output bit is 0.
  - s={s[5:0],in_bit}.
  - The recovery counter increments.
- When the recovery counter reaches 7 (possibly mid-beat), the following bits use the normal recursion. On the edge the beat completes, seed_out=s and seed_valid pulses once.
- busy = (FSM==RUN) || out_valid.
- A frame shorter than ceil(7/DW) beats in descramble mode completes normally; seed_valid never pulses and seed_out holds its previous value.
- Reset mid-frame: everything returns to its reset value on the next edge, and any pending output is dropped.
- in_ready is 0 in IDLE. in_valid in IDLE is ignored.

Optional Feature:
- Macro: SCR_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), sampled at start.
  - If set, out_data=in_data for the whole frame, with the same handshake, latency and out_last behaviour.
  - s is not advanced and seed_valid does not pulse.
- When undefined: the port is absent and the behaviour is as above.

Test Plan:
- DW=4, mode=0, seed_in=7'h7F, frame_len=4, in_data all 0 -> out_data 4'h0, 4'h7, 4'hF, 4'h4; out_last only on the 4th beat; seed_valid pulses at start.
- Round trip: scramble 32 random bits with seed 7'h5D and SERVICE bits 0..6=0, then feed the result through mode=1 -> seed_valid pulse with seed_out equal to the scrambler state after 7 bits; first 7 output bits are 0; remaining bits match the original input.
- Backpressure: toggle out_ready 1,0,0,1 during a frame -> out_data is stable while stalled, in_ready=0 while stalled, no beat lost or duplicated, 1-cycle latency otherwise.
- Ignored starts: start while busy; start with frame_len=0 -> no state change, seed_out unchanged, no seed_valid pulse.
- Reset asserted on the 2nd beat of a 4-beat frame -> next cycle busy=0, out_valid=0, s=7'h7F; a new frame then produces the reference sequence from the first scenario.
- DW=1, mode=1, frame_len=3 -> three 0 outputs, no seed_valid pulse, clean return to IDLE.
